dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: the pipeline MEM stage (requester P) and a debug/loader port (requester D).
- Latches the winning request and holds it on the memory interface for LATENCY cycles.
- Returns read data and a one-cycle done pulse, and stalls the pipeline while its access is outstanding.
- Sits between the MEM stage and the memory unit.

Parameters:
- LATENCY, 1, memory access cycles per request (>=1).
- MAX_WAIT, 4, arbitration losses D tolerates before forced grant (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- p_isLd  input  1  MEM-stage load request.
- p_isSt  input  1  MEM-stage store request.
- p_addr  input  32  MEM-stage address.
- p_wdata  input  32  MEM-stage store data.
- p_stall  output  1  freeze pipeline; P access not yet done.
- p_done  output  1  one-cycle pulse, P access complete.
- p_rdata  output  32  load data for P, valid while p_done=1 and held after.
- d_req  input  1  debug request, held until d_done.
- d_we  input  1  1=write, 0=read.
- d_addr  input  32  debug address.
- d_wdata  input  32  debug write data.
- d_gnt  output  1  one-cycle pulse when D request is accepted.
- d_done  output  1  one-cycle pulse, D access complete.
- d_rdata  output  32  read data for D, held after d_done.
- mem_isLd  output  1  to memory unit.
- mem_isSt  output  1  to memory unit.
- mem_address  output  32  to memory unit.
- mem_data_in  output  32  to memory unit.
- mem_data_out  input  32  from memory unit.

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0. All outputs 0, except p_stall, which follows the combinational rule below.
- Reset mid-access aborts the access: no done pulse, mem_isLd/mem_isSt drop immediately.
- p_req = p_isLd | p_isSt.
- p_stall = p_req & ~p_done, combinational.
- P holds its request and operands stable while stalled.
- FSM states: IDLE, BUSY_P, BUSY_D.
- IDLE:
  - mem_isLd=mem_isSt=0, mem_address=0, mem_data_in=0.
  - If p_req: latch owner=P, addr, wdata, ld/st; load counter=LATENCY-1; go BUSY_P.
  - Else if d_req: same latch for D; pulse d_gnt; go BUSY_D.
  - P has strict priority; simultaneous requests give P the grant.
- BUSY_x:
  - Drive the latched request onto mem_* every cycle. Stores may write repeatedly with identical data.
  - Counter decrements each cycle.
  - Cycle with counter=0 is the final cycle: capture mem_data_out into p_rdata or d_rdata (loads only; stores leave rdata unchanged), pulse p_done or d_done, return to IDLE.
- Latency: request sampled in IDLE. Done occurs 1+LATENCY cycles after the request is first presented with no contention, i.e. LATENCY=1 gives done in the 2nd cycle.
- One mandatory IDLE bubble between consecutive accesses.
- A P request present in the cycle after p_done is a new instruction's request.
- p_isLd and p_isSt both 1 is illegal: treated as a store, mem_isLd=0.
- d_req dropped before d_done: access still completes, d_done still pulses.
- Latched operands are immune to input changes during BUSY.

Optional Feature:
- Macro DMEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A wait counter (saturating at MAX_WAIT) increments on each IDLE cycle where d_req and p_req are both 1 and P wins.
  - When it equals MAX_WAIT, the next IDLE arbitration grants D even if p_req=1 (p_stall stays 1).
  - The counter clears on d_gnt and on reset.
- Undefined: strict P priority; the counter logic is absent.

Test Plan:
- LATENCY=1, p_isLd=1, p_addr=0x10, memory holds 0xDEADBEEF:
  - p_stall=1 for 1 cycle.
  - p_done pulses on cycle 2 with p_rdata=0xDEADBEEF.
  - mem_isLd=1 only on cycle 2.
- LATENCY=3, p_isSt=1, p_addr=0x20, p_wdata=0x12345678:
  - mem_isSt=1 for 3 cycles; p_done on cycle 4.
  - A subsequent load of 0x20 returns 0x12345678.
- Simultaneous p_isLd and d_req (read, addr 0x30):
  - P served first.
  - d_gnt pulses in the IDLE cycle after p_done; d_done follows LATENCY cycles later.
- Guard enabled, MAX_WAIT=2, p_isLd held continuously and d_req held:
  - D granted on the 3rd arbitration.
  - p_stall stays high through the D access.
- Assert rst=0 during BUSY_P cycle 2 of LATENCY=3:
  - mem_isSt=0 immediately; no p_done.
  - After release, state is IDLE and a fresh request completes normally.
- Guard disabled, same stimulus as the starvation test: D never granted while p_req is held.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage (P)
// and a debug/loader port (D); P has priority, each access lasts LATENCY cycles.
// Ports: clk, rst (async, active-low); P side p_isLd/p_isSt/p_addr/p_wdata in,
//   p_stall/p_done/p_rdata out; D side d_req/d_we/d_addr/d_wdata in,
//   d_gnt/d_done/d_rdata out; memory side mem_isLd/mem_isSt/mem_address/
//   mem_data_in out, mem_data_out in.
// Option: DMEM_ARB_STARVE_GUARD_EN forces a D grant after MAX_WAIT lost
//   arbitrations.
module dmem_arbiter #(
   parameter int LATENCY  = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p_isLd,
   input  logic        p_isSt,
   input  logic [31:0] p_addr,
   input  logic [31:0] p_wdata,
   output logic        p_stall,
   output logic        p_done,
   output logic [31:0] p_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        mem_isLd,
   output logic        mem_isSt,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   typedef enum logic [1:0] {IDLE, BUSY_P, BUSY_D} state_t;

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          ld_q, st_q;
   logic [31:0]   addr_q, wdata_q;
   logic [31:0]   p_rdata_q, d_rdata_q;
   logic          p_done_q, d_done_q;

   logic p_req, idle, last, force_d;
   logic gnt_p, gnt_d;

   assign p_req = p_isLd | p_isSt;
   assign idle  = (state_q == IDLE);
   assign last  = (cnt_q == '0);

   // rst gating keeps d_gnt low while reset is held
   assign gnt_d = rst & idle & d_req & (~p_req | force_d);
   assign gnt_p = rst & idle & p_req & ~gnt_d;

   assign mem_isLd    = ld_q;
   assign mem_isSt    = st_q;
   assign mem_address = addr_q;
   assign mem_data_in = wdata_q;

   assign p_done  = p_done_q;
   assign d_done  = d_done_q;
   assign d_gnt   = gnt_d;
   assign p_stall = p_req & ~p_done_q;

   // load data is visible already in the done cycle
   assign p_rdata = (p_done_q & ld_q) ? mem_data_out : p_rdata_q;
   assign d_rdata = (d_done_q & ld_q) ? mem_data_out : d_rdata_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         ld_q      <= 1'b0;
         st_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         p_rdata_q <= '0;
         d_rdata_q <= '0;
         p_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gnt_p) begin
                  state_q  <= BUSY_P;
                  ld_q     <= p_isLd & ~p_isSt;
                  st_q     <= p_isSt;
                  addr_q   <= p_addr;
                  wdata_q  <= p_wdata;
                  cnt_q    <= CNT_INIT;
                  p_done_q <= (CNT_INIT == '0);
               end else if (gnt_d) begin
                  state_q  <= BUSY_D;
                  ld_q     <= ~d_we;
                  st_q     <= d_we;
                  addr_q   <= d_addr;
                  wdata_q  <= d_wdata;
                  cnt_q    <= CNT_INIT;
                  d_done_q <= (CNT_INIT == '0);
               end
            end
            BUSY_P, BUSY_D: begin
               if (last) begin
                  state_q  <= IDLE;
                  ld_q     <= 1'b0;
                  st_q     <= 1'b0;
                  addr_q   <= '0;
                  wdata_q  <= '0;
                  p_done_q <= 1'b0;
                  d_done_q <= 1'b0;
                  if (ld_q && state_q == BUSY_P)
                     p_rdata_q <= mem_data_out;
                  if (ld_q && state_q == BUSY_D)
                     d_rdata_q <= mem_data_out;
               end else begin
                  cnt_q    <= cnt_q - 1'b1;
                  p_done_q <= (state_q == BUSY_P) &&
                              (cnt_q == CW'(1));
                  d_done_q <= (state_q == BUSY_D) &&
                              (cnt_q == CW'(1));
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   logic [WW-1:0] wait_q;

   assign force_d = (wait_q == WW'(MAX_WAIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wait_q <= '0;
      else if (gnt_d)
         wait_q <= '0;
      else if (gnt_p && d_req && !force_d)
         wait_q <= wait_q + 1'b1;
   end
`else
   // strict P priority: never forced
   assign force_d = (MAX_WAIT < 0);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + random checks of dmem_arbiter at LATENCY 1
// and 3 against a transaction-level model with a word memory per instance.
module tb_dmem_arbiter;

   localparam int MW = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        sel, mem_init;
   logic        p_isLd, p_isSt, d_req, d_we;
   logic [31:0] p_addr, p_wdata, d_addr, d_wdata;

   logic        a_ld, a_st, a_dr, b_ld, b_st, b_dr;
   logic        a_stall, a_pdone, a_gnt, a_ddone, a_mld, a_mst;
   logic        b_stall, b_pdone, b_gnt, b_ddone, b_mld, b_mst;
   logic [31:0] a_prd, a_drd, a_maddr, a_mdin, a_mdout;
   logic [31:0] b_prd, b_drd, b_maddr, b_mdin, b_mdout;
   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];

   assign a_ld = p_isLd & ~sel;
   assign a_st = p_isSt & ~sel;
   assign a_dr = d_req & ~sel;
   assign b_ld = p_isLd & sel;
   assign b_st = p_isSt & sel;
   assign b_dr = d_req & sel;

   dmem_arbiter #(.LATENCY(1)) u_a (
      .clk(clk), .rst(rst),
      .p_isLd(a_ld), .p_isSt(a_st),
      .p_addr(p_addr), .p_wdata(p_wdata),
      .p_stall(a_stall), .p_done(a_pdone), .p_rdata(a_prd),
      .d_req(a_dr), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(a_gnt), .d_done(a_ddone), .d_rdata(a_drd),
      .mem_isLd(a_mld), .mem_isSt(a_mst),
      .mem_address(a_maddr), .mem_data_in(a_mdin),
      .mem_data_out(a_mdout)
   );

   dmem_arbiter #(.LATENCY(3), .MAX_WAIT(MW)) u_b (
      .clk(clk), .rst(rst),
      .p_isLd(b_ld), .p_isSt(b_st),
      .p_addr(p_addr), .p_wdata(p_wdata),
      .p_stall(b_stall), .p_done(b_pdone), .p_rdata(b_prd),
      .d_req(b_dr), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(b_gnt), .d_done(b_ddone), .d_rdata(b_drd),
      .mem_isLd(b_mld), .mem_isSt(b_mst),
      .mem_address(b_maddr), .mem_data_in(b_mdin),
      .mem_data_out(b_mdout)
   );

   function automatic logic [31:0] seed(input int i);
      return (i == 4) ? 32'hDEADBEEF : (32'hA5A50000 ^ (32'(i) << 4));
   endfunction

   assign a_mdout = mem_a[a_maddr[5:2]];
   assign b_mdout = mem_b[b_maddr[5:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) begin
            mem_a[i] <= seed(i);
            mem_b[i] <= seed(i);
         end
      end else begin
         if (a_mst) mem_a[a_maddr[5:2]] <= a_mdin;
         if (b_mst) mem_b[b_maddr[5:2]] <= b_mdin;
      end
   end

   logic        o_stall, o_pdone, o_gnt, o_ddone, o_mld, o_mst;
   logic [31:0] o_prd, o_drd, o_maddr, o_mdin;
   assign o_stall = sel ? b_stall : a_stall;
   assign o_pdone = sel ? b_pdone : a_pdone;
   assign o_gnt   = sel ? b_gnt   : a_gnt;
   assign o_ddone = sel ? b_ddone : a_ddone;
   assign o_mld   = sel ? b_mld   : a_mld;
   assign o_mst   = sel ? b_mst   : a_mst;
   assign o_prd   = sel ? b_prd   : a_prd;
   assign o_drd   = sel ? b_drd   : a_drd;
   assign o_maddr = sel ? b_maddr : a_maddr;
   assign o_mdin  = sel ? b_mdin  : a_mdin;

   logic [31:0] ref_m [2][16];
   logic [31:0] exp_prd [2];
   logic [31:0] exp_drd [2];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input bit up, input bit pld, input bit pst,
                          input logic [31:0] pa, input logic [31:0] pw,
                          input bit ud, input bit dwe,
                          input logic [31:0] da, input logic [31:0] dw,
                          input bit scr, input bit early);
      int L, k, ep, eg, ed, lc, gp, gg, gd;
      int np, ng, nd, nld, nst, eld, est, bad;
      logic [31:0] prd_d, drd_d;
      bit p_on;
      k = sel ? 1 : 0;
      L = sel ? 3 : 1;
      ep = up ? 1 + L : 0;
      eg = !ud ? 0 : (up ? 2 + L : 1);
      ed = !ud ? 0 : eg + L;
      eld = 0; est = 0;
      if (up) begin
         if (pst) begin
            ref_m[k][pa[5:2]] = pw; est += L;
         end else begin
            exp_prd[k] = ref_m[k][pa[5:2]]; eld += L;
         end
      end
      if (ud) begin
         if (dwe) begin
            ref_m[k][da[5:2]] = dw; est += L;
         end else begin
            exp_drd[k] = ref_m[k][da[5:2]]; eld += L;
         end
      end
      lc = ((ep > ed) ? ep : ed) + 2;
      gp = 0; gg = 0; gd = 0; np = 0; ng = 0; nd = 0;
      nld = 0; nst = 0; bad = 0; prd_d = '0; drd_d = '0;
      @(posedge clk); #1;
      p_isLd = up & pld; p_isSt = up & pst;
      p_addr = pa; p_wdata = pw;
      d_req = ud; d_we = dwe; d_addr = da; d_wdata = dw;
      p_on = up;
      for (int c = 1; c <= lc; c++) begin
         @(negedge clk);
         if (o_pdone) begin np++; gp = c; prd_d = o_prd; end
         if (o_gnt) begin ng++; gg = c; end
         if (o_ddone) begin nd++; gd = c; drd_d = o_drd; end
         if (o_mld) nld++;
         if (o_mst) nst++;
         if (o_stall !== (p_on && c != ep)) bad++;
         @(posedge clk); #1;
         if (gp == c) begin p_isLd = 0; p_isSt = 0; p_on = 0; end
         if (gd == c) d_req = 0;
         if (gg == c && scr) begin
            d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we;
         end
         if (gg == c && early) d_req = 0;
      end
      chk("p_done_cnt", np, 32'(up));
      chk("p_done_cyc", gp, ep);
      if (up && pld && !pst) chk("p_rdata_done", prd_d, exp_prd[k]);
      chk("p_rdata_hold", o_prd, exp_prd[k]);
      chk("d_gnt_cnt", ng, 32'(ud));
      chk("d_gnt_cyc", gg, eg);
      chk("d_done_cnt", nd, 32'(ud));
      chk("d_done_cyc", gd, ed);
      if (ud && !dwe) chk("d_rdata_done", drd_d, exp_drd[k]);
      chk("d_rdata_hold", o_drd, exp_drd[k]);
      chk("mem_ld_cycles", nld, eld);
      chk("mem_st_cycles", nst, est);
      chk("p_stall_rule", bad, 0);
   endtask

   initial begin
      int gp_n, gg, gd, bad, pdrop, eg, epn, ng;
      logic [31:0] drd;
      sel = 1'b1; mem_init = 1'b1;
      p_isLd = 1'b1; p_isSt = 1'b0; d_req = 1'b1; d_we = 1'b0;
      p_addr = '0; p_wdata = '0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 16; i++) begin
         ref_m[0][i] = seed(i);
         ref_m[1][i] = seed(i);
      end
      exp_prd[0] = '0; exp_prd[1] = '0;
      exp_drd[0] = '0; exp_drd[1] = '0;
      @(posedge clk); #1;
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst_stall", o_stall, 1);
      chk("rst_gnt", o_gnt, 0);
      chk("rst_pdone", o_pdone, 0);
      chk("rst_ddone", o_ddone, 0);
      chk("rst_mld", o_mld, 0);
      chk("rst_mst", o_mst, 0);
      chk("rst_maddr", o_maddr, 0);
      chk("rst_mdin", o_mdin, 0);
      chk("rst_prd", o_prd, 0);
      chk("rst_drd", o_drd, 0);
      p_isLd = 1'b0; d_req = 1'b0;
      #1 chk("rst_stall_off", o_stall, 0);
      @(negedge clk) rst = 1'b1;

      sel = 1'b0;
      run_txn(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      sel = 1'b1;
      run_txn(1, 0, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 0, 0);
      run_txn(1, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);
      run_txn(1, 1, 0, 32'h00, 0, 1, 0, 32'h30, 0, 0, 0);
      run_txn(1, 1, 1, 32'h24, 32'h0BADF00D, 0, 0, 0, 0, 0, 0);
      run_txn(0, 0, 0, 0, 0, 1, 1, 32'h30, 32'h55AA33CC, 1, 1);
      run_txn(0, 0, 0, 0, 0, 1, 0, 32'h30, 0, 1, 0);

      for (int n = 0; n < 40; n++) begin
         int kind, r;
         bit up, ud, pl, ps;
         sel = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 2);
         r = $urandom_range(0, 7);
         up = (kind != 1);
         ud = (kind != 0);
         pl = (r < 4);
         ps = (r == 0) || (r >= 4);
         run_txn(up, pl, ps, 32'($urandom_range(0, 7)) << 2, $urandom,
                 ud, 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 7)) << 2, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      sel = 1'b1;
      @(posedge clk); #1;
      p_isSt = 1'b1; p_addr = 32'h3C; p_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("rst_mid_pre_st", o_mst, 1);
      rst = 1'b0;
      #1;
      chk("rst_mid_mst", o_mst, 0);
      chk("rst_mid_maddr", o_maddr, 0);
      chk("rst_mid_pdone", o_pdone, 0);
      p_isSt = 1'b0;
      @(negedge clk);
      chk("rst_mid_pdone2", o_pdone, 0);
      @(negedge clk);
      chk("rst_mid_pdone3", o_pdone, 0);
      chk("rst_mid_prd", o_prd, 0);
      rst = 1'b1;
      ref_m[1][15] = 32'hCAFEF00D;
      exp_prd[0] = '0; exp_prd[1] = '0;
      exp_drd[0] = '0; exp_drd[1] = '0;
      run_txn(1, 1, 0, 32'h3C, 0, 0, 0, 0, 0, 0, 0);

`ifdef DMEM_ARB_STARVE_GUARD_EN
      pdrop = 17; eg = 9; epn = 3;
`else
      pdrop = 41; eg = 41; epn = 10;
`endif
      gp_n = 0; gg = 0; gd = 0; bad = 0; ng = 0; drd = '0;
      exp_drd[1] = ref_m[1][2];
      @(posedge clk); #1;
      p_isLd = 1'b1; p_addr = 32'h00;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
      for (int c = 1; c <= pdrop + 4; c++) begin
         @(negedge clk);
         if (o_pdone) gp_n++;
         if (o_gnt) begin ng++; gg = c; end
         if (o_ddone) begin gd = c; drd = o_drd; end
         if (p_isLd && gg != 0 && (gd == 0 || gd == c) && o_stall !== 1'b1)
            bad++;
         @(posedge clk); #1;
         if (gd == c) d_req = 1'b0;
         if (c + 1 == pdrop) p_isLd = 1'b0;
      end
      chk("starve_gnt_cyc", gg, eg);
      chk("starve_gnt_cnt", ng, 1);
      chk("starve_ddone_cyc", gd, eg + 3);
      chk("starve_pdone_cnt", gp_n, epn);
      chk("starve_drdata", drd, exp_drd[1]);
      chk("starve_stall_hold", bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
